// File: rtl/lb_bus_pkg.sv
// ---------------------------------------------------------------------------
// lb_bus_pkg
// Shared definitions for the UART local-bus arbiter slice.
//  - lb_state_t : sequencer states (IDLE, SETUP, STROBE, HOLD)
//  - M0 / M1    : master index values used for grant and last_gnt
//  - LB_DW/LB_AW: default local-bus data and address widths
// ---------------------------------------------------------------------------
package lb_bus_pkg;

    // Default local-bus geometry of the UART register file.
    localparam int LB_DW = 8;
    localparam int LB_AW = 1;

    // Master indices. A grant is a single bit holding one of these values.
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Access sequencer states. Every access walks all four states in order,
    // so IDLE is always visited between two accesses.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } lb_state_t;

endpackage

// File: rtl/lb_arb_pick.sv
// ---------------------------------------------------------------------------
// lb_arb_pick
// Combinational winner select between the two local-bus masters.
// Build option:
//   LB_ARB_FIXED_PRIO_EN defined   -> master 0 always wins a tie (m1 can
//                                     starve), last_gnt is ignored.
//   LB_ARB_FIXED_PRIO_EN undefined -> round-robin: on a tie the master that
//                                     did not win last time gets the grant.
// Ports:
//   req0     in  master 0 request level
//   req1     in  master 1 request level
//   last_gnt in  index of the master granted most recently
//   gnt      out index of the winning master (only meaningful if a req is up)
// ---------------------------------------------------------------------------
module lb_arb_pick
    import lb_bus_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt
);

`ifdef LB_ARB_FIXED_PRIO_EN

    // Fixed priority never looks at the grant history; the dummy sink keeps
    // the port connected without leaving a dangling input.
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;

    // Master 1 only wins when master 0 is not asking at all.
    always_comb begin
        gnt = M0;
        if (!req0 && req1) begin
            gnt = M1;
        end
    end

`else

    // A lone request always wins. On a tie the grant goes to whichever
    // master is not last_gnt, which alternates service under contention.
    always_comb begin
        gnt = M0;
        if (req0 && req1) begin
            gnt = ~last_gnt;
        end else if (req1) begin
            gnt = M1;
        end
    end

`endif

endmodule

// File: rtl/lb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// lb_bus_arbiter
// Two-master sequencer/arbiter for the UART local bus. Grants one of two
// level-requesting masters, then runs a fixed-length single access on the
// local bus: one SETUP cycle with address/data presented, ACC_CYC cycles of
// strobe (cs_n low with we or oe), and one HOLD cycle carrying the ack.
// Read data is captured on the last strobe edge and held until the next read.
// All outputs are registered.
// Build option: LB_ARB_FIXED_PRIO_EN selects fixed priority (m0 wins ties)
// instead of the default round-robin tie break (see lb_arb_pick).
// Parameters:
//   DW       local-bus data width
//   AW       local-bus address width
//   ACC_CYC  cycles cs_n stays low with the strobe asserted (>= 1)
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   m0_req/we/adrs/wdata/ack   master 0 request interface
//   m1_req/we/adrs/wdata/ack   master 1 request interface
//   rdata                      last read data, valid from the ack cycle
//   lb_cs_n/we/oe/adrs/wdata   local-bus outputs to the UART
//   lb_rdata                   local-bus read data from the UART
//   busy                       high whenever the sequencer is not IDLE
// ---------------------------------------------------------------------------
module lb_bus_arbiter
    import lb_bus_pkg::*;
#(
    parameter int DW      = LB_DW,
    parameter int AW      = LB_AW,
    parameter int ACC_CYC = 2
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adrs,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adrs,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,

    output logic [DW-1:0] rdata,

    output logic          lb_cs_n,
    output logic          lb_we,
    output logic          lb_oe,
    output logic [AW-1:0] lb_adrs,
    output logic [DW-1:0] lb_wdata,
    input  logic [DW-1:0] lb_rdata,

    output logic          busy
);

    // Strobe counter only has to reach ACC_CYC-1.
    localparam int CW = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;

    lb_state_t     state;
    logic [CW-1:0] strobe_cnt;
    logic          lat_gnt;
    logic          lat_we;
    logic          last_gnt;

    logic          pick_gnt;
    logic          any_req;
    logic          sel_we;
    logic [AW-1:0] sel_adrs;
    logic [DW-1:0] sel_wdata;

    // Winner select; the policy lives in the sub-module so the build option
    // touches only one small block.
    lb_arb_pick u_pick (
        .req0     (m0_req),
        .req1     (m1_req),
        .last_gnt (last_gnt),
        .gnt      (pick_gnt)
    );

    // Route the candidate winner's access parameters so IDLE can latch them
    // in the same edge that takes the grant.
    always_comb begin
        any_req   = m0_req | m1_req;
        sel_we    = m0_we;
        sel_adrs  = m0_adrs;
        sel_wdata = m0_wdata;
        if (pick_gnt == M1) begin
            sel_we    = m1_we;
            sel_adrs  = m1_adrs;
            sel_wdata = m1_wdata;
        end
    end

    // Access sequencer. lb_adrs and lb_wdata are loaded only at grant, so
    // they stay frozen for the whole access (master changes are ignored) and
    // keep their last value in IDLE so the slave never sees a glitch.
    // The ack is raised on the edge that ends the final strobe cycle, which
    // is the same edge that captures lb_rdata for reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            strobe_cnt <= '0;
            lat_gnt    <= M0;
            lat_we     <= 1'b0;
            last_gnt   <= M1;
            lb_cs_n    <= 1'b1;
            lb_we      <= 1'b0;
            lb_oe      <= 1'b0;
            lb_adrs    <= '0;
            lb_wdata   <= '0;
            rdata      <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    if (any_req) begin
                        lat_gnt  <= pick_gnt;
                        last_gnt <= pick_gnt;
                        lat_we   <= sel_we;
                        lb_adrs  <= sel_adrs;
                        lb_wdata <= sel_wdata;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end

                SETUP: begin
                    lb_cs_n    <= 1'b0;
                    lb_we      <= lat_we;
                    lb_oe      <= ~lat_we;
                    strobe_cnt <= CW'(ACC_CYC - 1);
                    state      <= STROBE;
                end

                STROBE: begin
                    if (strobe_cnt == '0) begin
                        lb_cs_n <= 1'b1;
                        lb_we   <= 1'b0;
                        lb_oe   <= 1'b0;
                        m0_ack  <= (lat_gnt == M0);
                        m1_ack  <= (lat_gnt == M1);
                        if (!lat_we) begin
                            rdata <= lb_rdata;
                        end
                        state   <= HOLD;
                    end else begin
                        strobe_cnt <= strobe_cnt - CW'(1);
                    end
                end

                HOLD: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    lb_cs_n <= 1'b1;
                    lb_we   <= 1'b0;
                    lb_oe   <= 1'b0;
                    m0_ack  <= 1'b0;
                    m1_ack  <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lb_bus_arbiter
// Directed bench for lb_bus_arbiter with ACC_CYC = 2: a table of single
// accesses followed by hand-written reset, arbitration, request-drop and
// input-change sequences.
// ---------------------------------------------------------------------------
module tb_lb_bus_arbiter;

    localparam int ACC = 2;
    localparam int LAT = 2 + ACC;
    localparam int GAP = 3 + ACC;

    logic       clk;
    logic       reset;
    logic       m0_req, m0_we, m0_ack;
    logic [0:0] m0_adrs;
    logic [7:0] m0_wdata;
    logic       m1_req, m1_we, m1_ack;
    logic [0:0] m1_adrs;
    logic [7:0] m1_wdata;
    logic [7:0] rdata;
    logic       lb_cs_n, lb_we, lb_oe;
    logic [0:0] lb_adrs;
    logic [7:0] lb_wdata;
    logic [7:0] lb_rdata;
    logic       busy;

    int total = 0;
    int bad   = 0;

    lb_bus_arbiter #(.DW(8), .AW(1), .ACC_CYC(ACC)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_adrs  (m0_adrs),
        .m0_wdata (m0_wdata),
        .m0_ack   (m0_ack),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_adrs  (m1_adrs),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .rdata    (rdata),
        .lb_cs_n  (lb_cs_n),
        .lb_we    (lb_we),
        .lb_oe    (lb_oe),
        .lb_adrs  (lb_adrs),
        .lb_wdata (lb_wdata),
        .lb_rdata (lb_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         master;
        logic       we;
        logic [0:0] adrs;
        logic [7:0] wdata;
        logic [7:0] slv;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one access for the given master and watches every cycle up to
    // the ack. mode 1 drops req in the first strobe cycle, mode 2 changes
    // we/adrs/wdata in the first strobe cycle.
    task automatic applyStimulus(input int master, input logic we, input logic [0:0] adrs,
                                 input logic [7:0] wdata, input logic [7:0] slv, input int mode,
                                 output int ack_cyc, output int cs_low, output bit seq_ok);
        lb_rdata = slv;
        if (master == 0) begin
            m0_we = we; m0_adrs = adrs; m0_wdata = wdata; m0_req = 1'b1;
        end else begin
            m1_we = we; m1_adrs = adrs; m1_wdata = wdata; m1_req = 1'b1;
        end
        ack_cyc = -1;
        cs_low  = 0;
        seq_ok  = 1'b1;
        for (int c = 1; c <= 20 && ack_cyc < 0; c++) begin
            tick();
            if (lb_cs_n === 1'b0) begin
                cs_low++;
                if (lb_we !== we || lb_oe !== ~we || lb_adrs !== adrs || lb_wdata !== wdata)
                    seq_ok = 1'b0;
                if (mode == 1) begin
                    if (master == 0) m0_req = 1'b0; else m1_req = 1'b0;
                end
                if (mode == 2) begin
                    if (master == 0) begin
                        m0_we = ~we; m0_adrs = ~adrs; m0_wdata = wdata + 8'h11;
                    end else begin
                        m1_we = ~we; m1_adrs = ~adrs; m1_wdata = wdata + 8'h11;
                    end
                end
            end
            if ((master == 0 && m1_ack !== 1'b0) || (master == 1 && m0_ack !== 1'b0))
                seq_ok = 1'b0;
            if ((master == 0 && m0_ack === 1'b1) || (master == 1 && m1_ack === 1'b1))
                ack_cyc = c;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    initial begin
        int ack_cyc, cs_low, n, extra;
        bit seq_ok;
        int got[4];
        int when[4];
        int exp_order[4];

        vecs[0] = '{0, 1'b1, 1'b1, 8'hA5, 8'hFF, 8'h00};
        vecs[1] = '{1, 1'b0, 1'b0, 8'h00, 8'h3C, 8'h3C};
        vecs[2] = '{0, 1'b0, 1'b1, 8'h44, 8'h5A, 8'h5A};
        vecs[3] = '{1, 1'b1, 1'b0, 8'h77, 8'h99, 8'h5A};
        vecs[4] = '{1, 1'b0, 1'b1, 8'hC3, 8'h00, 8'h00};
        vecs[5] = '{0, 1'b1, 1'b0, 8'hFF, 8'h12, 8'h00};

`ifdef LB_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif

        clk = 1'b0; reset = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_adrs = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_adrs = '0; m1_wdata = '0;
        lb_rdata = '0;

        tick(); tick();
        checkOutput("reset cs_n",  lb_cs_n, 1);
        checkOutput("reset we/oe", {lb_we, lb_oe}, 0);
        checkOutput("reset acks",  {m0_ack, m1_ack}, 0);
        checkOutput("reset busy",  busy, 0);
        checkOutput("reset rdata", rdata, 0);
        checkOutput("reset adrs/wdata", {lb_adrs, lb_wdata}, 0);
        reset = 1'b0;
        tick();

        // Table of single accesses.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].master, vecs[i].we, vecs[i].adrs, vecs[i].wdata,
                          vecs[i].slv, 0, ack_cyc, cs_low, seq_ok);
            checkOutput($sformatf("v%0d ack latency", i), ack_cyc, LAT);
            checkOutput($sformatf("v%0d strobe length", i), cs_low, ACC);
            checkOutput($sformatf("v%0d strobe signals", i), seq_ok, 1);
            checkOutput($sformatf("v%0d rdata", i), rdata, vecs[i].exp_rdata);
            lb_rdata = 8'hEE;
            tick();
            checkOutput($sformatf("v%0d idle busy", i), busy, 0);
            checkOutput($sformatf("v%0d idle cs_n", i), lb_cs_n, 1);
            checkOutput($sformatf("v%0d held adrs", i), lb_adrs, vecs[i].adrs);
            checkOutput($sformatf("v%0d held wdata", i), lb_wdata, vecs[i].wdata);
            checkOutput($sformatf("v%0d held rdata", i), rdata, vecs[i].exp_rdata);
        end

        // Reset in the middle of a read strobe clears outputs immediately.
        lb_rdata = 8'h81;
        m0_we = 1'b0; m0_adrs = 1'b1; m0_req = 1'b1;
        n = 0;
        for (int c = 0; c < 10 && lb_cs_n !== 1'b0; c++) begin
            tick();
            n++;
        end
        checkOutput("t1 strobe reached", lb_cs_n, 0);
        m0_req = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t1 cs_n", lb_cs_n, 1);
        checkOutput("t1 we/oe", {lb_we, lb_oe}, 0);
        checkOutput("t1 acks", {m0_ack, m1_ack}, 0);
        checkOutput("t1 busy", busy, 0);
        checkOutput("t1 rdata", rdata, 0);
        tick();
        reset = 1'b0;
        tick();

        // Both masters requesting continuously from reset.
        m0_we = 1'b1; m0_adrs = 1'b0; m0_wdata = 8'h01;
        m1_we = 1'b1; m1_adrs = 1'b1; m1_wdata = 8'h02;
        m0_req = 1'b1; m1_req = 1'b1;
        n = 0;
        got  = '{-1, -1, -1, -1};
        when = '{0, 0, 0, 0};
        for (int c = 1; c <= 40 && n < 4; c++) begin
            tick();
            if (m0_ack === 1'b1) begin
                got[n] = 0; when[n] = c; n++;
            end else if (m1_ack === 1'b1) begin
                got[n] = 1; when[n] = c; n++;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        checkOutput("t4 ack count", n, 4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("t4 grant %0d", i), got[i], exp_order[i]);
        checkOutput("t4 first latency", when[0], LAT);
        checkOutput("t4 spacing", when[1] - when[0], GAP);
        tick(); tick();
        checkOutput("t4 idle busy", busy, 0);

        // Request dropped during the strobe: access still completes once.
        applyStimulus(0, 1'b1, 1'b1, 8'h5A, 8'h00, 1, ack_cyc, cs_low, seq_ok);
        checkOutput("t5 ack latency", ack_cyc, LAT);
        checkOutput("t5 strobe length", cs_low, ACC);
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (m0_ack === 1'b1 || lb_cs_n === 1'b0) extra++;
        end
        checkOutput("t5 no reaccess", extra, 0);
        checkOutput("t5 busy", busy, 0);
        checkOutput("t5 rdata", rdata, 0);

        // Master changes its inputs during the strobe: latched values hold.
        applyStimulus(0, 1'b1, 1'b0, 8'h11, 8'h00, 2, ack_cyc, cs_low, seq_ok);
        checkOutput("t6 frozen strobe", seq_ok, 1);
        checkOutput("t6 ack latency", ack_cyc, LAT);
        tick();
        checkOutput("t6 held wdata", lb_wdata, 8'h11);
        checkOutput("t6 held adrs", lb_adrs, 0);
        checkOutput("t6 rdata", rdata, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
